x_ddr_deser: RTL and testbench

X_DDR_DESER -- requirements
Module: x_ddr_deser

---
 rtl/x_ddr_deser.sv | 104 ++++++++++
 tb/tb_x_ddr_deser.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/x_ddr_deser.sv
// x_ddr_deser: deserializes Q0/Q1 DDR bit pairs into WIDTH-bit words and
// aligns word boundaries to TRAIN_PATTERN by slipping one bit at a time.
module x_ddr_deser #(
    parameter int               WIDTH         = 8,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = 8'hA5,
    parameter int               LOCK_COUNT    = 4
) (
    input  logic             C,
    input  logic             R_N,
    input  logic             CE,
    input  logic             Q0,
    input  logic             Q1,
    input  logic             TRAIN,
    output logic [WIDTH-1:0] DOUT,
    output logic             DVALID,
    output logic             LOCKED,
    output logic [3:0]       SLIP_CNT
);
    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {ST_HUNT, ST_SLIP_WAIT, ST_CHECK, ST_LOCKED} state_t;

    state_t           state;
    logic [WIDTH+1:0] sr;
    logic [WIDTH+3:0] cat;
    logic [CW-1:0]    cnt, nxt;
    logic [3:0]       match;
    logic             slip;

    // Newest bits sit at the LSB end; unconsumed bits are the low nxt bits of cat.
    assign cat = {sr, Q0, Q1};
    assign nxt = cnt + CW'(2) - CW'(slip);

    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            sr     <= '0;
            cnt    <= '0;
            DOUT   <= '0;
            DVALID <= 1'b0;
        end else if (CE) begin
            sr     <= cat[WIDTH+1:0];
            DVALID <= nxt >= CW'(WIDTH);
            if (nxt >= CW'(WIDTH)) begin
                cnt  <= nxt - CW'(WIDTH);
                DOUT <= WIDTH'(cat >> (nxt - CW'(WIDTH)));
            end else begin
                cnt <= nxt;
            end
        end else begin
            DVALID <= 1'b0;
        end
    end

    // Evaluates the word registered on the previous edge; runs regardless of CE
    // so a word is never missed, while the slip waits for the next CE edge.
    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            state    <= ST_HUNT;
            match    <= '0;
            slip     <= 1'b0;
            LOCKED   <= 1'b0;
            SLIP_CNT <= '0;
        end else if (!TRAIN) begin
            state  <= ST_HUNT;
            match  <= '0;
            slip   <= 1'b0;
            LOCKED <= 1'b0;
        end else begin
            if (CE)
                slip <= 1'b0;
            if (DVALID) begin
                case (state)
                    ST_HUNT: begin
                        if (DOUT == TRAIN_PATTERN) begin
                            match  <= 4'd1;
                            state  <= (LOCK_COUNT == 1) ? ST_LOCKED : ST_CHECK;
                            LOCKED <= LOCK_COUNT == 1;
                        end else begin
                            slip     <= 1'b1;
                            SLIP_CNT <= SLIP_CNT + 4'd1;
                            state    <= ST_SLIP_WAIT;
                        end
                    end
                    ST_SLIP_WAIT: state <= ST_HUNT;
                    ST_CHECK: begin
                        if (DOUT == TRAIN_PATTERN) begin
                            match <= match + 4'd1;
                            if (match + 4'd1 == 4'(LOCK_COUNT)) begin
                                state  <= ST_LOCKED;
                                LOCKED <= 1'b1;
                            end
                        end else begin
                            slip     <= 1'b1;
                            SLIP_CNT <= SLIP_CNT + 4'd1;
                            match    <= '0;
                            state    <= ST_SLIP_WAIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_x_ddr_deser.sv
// tb_x_ddr_deser: vector table, bit-queue scoreboard and alignment sequences
// for x_ddr_deser with WIDTH=8, TRAIN_PATTERN=8'hA5, LOCK_COUNT=4.
module tb_x_ddr_deser;
    localparam int W = 8;
    localparam logic [W-1:0] PAT = 8'hA5;

    logic C = 1'b0, R_N = 1'b0, CE = 1'b0, Q0 = 1'b0, Q1 = 1'b0, TRAIN = 1'b0;
    logic [W-1:0] DOUT;
    logic DVALID, LOCKED;
    logic [3:0] SLIP_CNT;

    int vectors = 0, miscompares = 0;
    int bi = 0, n = 0, prev = 0;
    bit wrapped = 0;
    bit sb_on = 0;
    bit mq[$];
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic q0, q1, ce, dv;
        logic [W-1:0] dout;
    } vec_t;
    vec_t tbl[12];

    x_ddr_deser #(.WIDTH(W), .TRAIN_PATTERN(PAT), .LOCK_COUNT(4)) dut (
        .C(C), .R_N(R_N), .CE(CE), .Q0(Q0), .Q1(Q1), .TRAIN(TRAIN),
        .DOUT(DOUT), .DVALID(DVALID), .LOCKED(LOCKED), .SLIP_CNT(SLIP_CNT)
    );

    always #5 C = ~C;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive on the falling edge, model the edge, sample 1ns after it.
    task automatic step(input logic q0, input logic q1, input logic ce, input logic train);
        logic [W-1:0] w;
        @(negedge C);
        Q0 = q0; Q1 = q1; CE = ce; TRAIN = train;
        @(posedge C);
        if (sb_on && ce) begin
            mq.push_back(q0);
            mq.push_back(q1);
            if (mq.size() >= W) begin
                w = '0;
                for (int i = 0; i < W; i++) w = {w[W-2:0], mq.pop_front()};
                exp_q.push_back(w);
            end
        end
        #1;
        if (sb_on) begin
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                chk("sb_dvalid", 32'(DVALID), 1);
                chk("sb_dout", 32'(DOUT), 32'(w));
            end else begin
                chk("sb_dvalid", 32'(DVALID), 0);
            end
        end
    endtask

    function automatic logic sbit(input int i, input int off, input logic [W-1:0] pat);
        return (i < off) ? 1'b0 : pat[W-1-((i-off)%W)];
    endfunction

    task automatic feed(input int off, input logic [W-1:0] pat, input logic ce, input logic train);
        step(ce ? sbit(bi, off, pat) : 1'b0, ce ? sbit(bi + 1, off, pat) : 1'b0, ce, train);
        if (ce) bi += 2;
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic do_reset();
        @(posedge C);
        #3;
        R_N = 1'b0; CE = 1'b0; TRAIN = 1'b0;
        #1;
        chk("rst_dout", 32'(DOUT), 0);
        chk("rst_dvalid", 32'(DVALID), 0);
        chk("rst_locked", 32'(LOCKED), 0);
        chk("rst_slip_cnt", 32'(SLIP_CNT), 0);
        @(negedge C);
        R_N = 1'b1;
        bi = 0;
        mq.delete();
        exp_q.delete();
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hA5};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            if (i == 4) do_reset();
            step(tbl[i].q0, tbl[i].q1, tbl[i].ce, 1'b0);
            chk($sformatf("tbl%0d_dvalid", i), 32'(DVALID), 32'(tbl[i].dv));
            chk($sformatf("tbl%0d_dout", i), 32'(DOUT), 32'(tbl[i].dout));
        end
        chk("tbl_locked", 32'(LOCKED), 0);

        do_reset();
        sb_on = 1;
        for (int i = 0; i < 60; i++)
            step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
        sb_on = 0;
        chk("sb_locked", 32'(LOCKED), 0);

        do_reset();
        for (int e = 1; e <= 20; e++) begin
            feed(0, PAT, 1'b1, 1'b1);
            chk("al_dvalid", 32'(DVALID), 32'(e % 4 == 0));
            if (e % 4 == 0) chk("al_dout", 32'(DOUT), 32'(PAT));
            if (e == 16 || e == 17) chk("al_locked", 32'(LOCKED), 32'(e == 17));
        end
        chk("al_slip_cnt", 32'(SLIP_CNT), 0);

        do_reset();
        for (int e = 0; e < 120 && !LOCKED; e++) feed(3, PAT, 1'b1, 1'b1);
        chk("off3_locked", 32'(LOCKED), 1);
        chk("off3_slip_cnt", 32'(SLIP_CNT), 3);
        n = 0;
        for (int e = 0; e < 12; e++) begin
            feed(3, PAT, 1'b1, 1'b1);
            if (DVALID) begin
                n++;
                chk("off3_dout", 32'(DOUT), 32'(PAT));
            end
        end
        chk("off3_words", 32'(n), 3);

        do_reset();
        for (int e = 1; e <= 4; e++) feed(1, PAT, 1'b1, 1'b1);
        feed(1, PAT, 1'b0, 1'b1);
        chk("gap_slip_req", 32'(SLIP_CNT), 1);
        for (int e = 0; e < 3; e++) begin
            feed(1, PAT, 1'b0, 1'b1);
            chk("gap_dvalid", 32'(DVALID), 0);
        end
        for (int e = 0; e < 60 && !LOCKED; e++) feed(1, PAT, 1'b1, 1'b1);
        chk("gap_locked", 32'(LOCKED), 1);
        chk("gap_slip_cnt", 32'(SLIP_CNT), 1);

        feed(1, PAT, 1'b1, 1'b0);
        chk("tr0_locked", 32'(LOCKED), 0);
        chk("tr0_slip_cnt", 32'(SLIP_CNT), 1);
        prev = int'(SLIP_CNT);
        wrapped = 0;
        for (int e = 0; e < 400 && !wrapped; e++) begin
            feed(0, 8'h00, 1'b1, 1'b1);
            if (int'(SLIP_CNT) != prev) begin
                chk("wrap_step", 32'(SLIP_CNT), 32'((prev + 1) % 16));
                wrapped = (prev == 15) && (SLIP_CNT == 4'd0);
                prev = int'(SLIP_CNT);
            end
        end
        chk("wrap_seen", 32'(wrapped), 1);
        chk("wrap_locked", 32'(LOCKED), 0);

        do_reset();
        for (int e = 0; e < 6; e++) feed(0, PAT, 1'b1, 1'b0);
        chk("mid_dout_pre", 32'(DOUT), 32'(PAT));
        do_reset();
        for (int e = 1; e <= 4; e++) begin
            feed(0, PAT, 1'b1, 1'b0);
            chk("mid_dvalid", 32'(DVALID), 32'(e == 4));
        end
        chk("mid_dout", 32'(DOUT), 32'(PAT));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
